// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port unified memory between instruction fetch (if_*) and
// load/store (dm_*). One access is in flight at a time. The granted request's
// address, write enable, write data and byte enables are latched onto mem_* and
// held until the memory acknowledges or the watchdog aborts. A registered
// one-cycle ready pulse is then returned to the owner. bus_err rides along with
// the ready pulse of an aborted access.
//
// Access timeline: grant edge -> BUSY (one or more cycles) -> DONE -> IDLE.
// The ready pulse is visible in the IDLE cycle that follows DONE. A requester
// is not eligible in its own ready cycle. As a result, two requesters that are
// both asserted continuously are granted alternately.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : a pointer favours the port that was not granted last (it
//               starts at dm after reset)
//   undefined : fixed dm-over-if priority, no pointer register
//
// Ports
//   CLK, RST                   clock (rising edge), async active-low reset
//   if_req/if_addr             fetch request, held until if_ready
//   if_rdata/if_ready          fetched word and completion pulse (registered)
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_be             load/store request, held until dm_ready
//   dm_rdata/dm_ready          load word and completion pulse (registered)
//   if_stall/dm_stall          x_req & ~x_ready (combinational)
//   bus_err                    pulses with the ready of an aborted access
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be           registered memory request
//   mem_rdata/mem_ack          memory read data and one-cycle completion
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ready,
    output logic                if_stall,
    output logic                dm_stall,
    output logic                bus_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);
    localparam int BE_W = DATA_W / 8;
    // Wide enough to hold TIMEOUT, and never zero bits wide.
    localparam int WD_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q,    mem_be_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
    logic                if_ready_q,  if_ready_d;
    logic                dm_ready_q,  dm_ready_d;
    logic                bus_err_q,   bus_err_d;
    logic                owner_dm_q,  owner_dm_d;
    logic                err_q,       err_d;
    logic [WD_W-1:0]     wd_q,        wd_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic                ptr_dm_q,    ptr_dm_d;
`endif

    logic                if_elig_s;
    logic                dm_elig_s;
    logic                dm_win_s;
    logic [WD_W-1:0]     wd_inc_s;
    logic                wd_expire_s;

    // Eligibility, arbitration winner and watchdog expiry.
    always_comb begin
        // A requester whose ready pulse is showing this cycle is dropping its request.
        if_elig_s   = if_req & ~if_ready_q;
        dm_elig_s   = dm_req & ~dm_ready_q;
`ifdef ARB_ROUND_ROBIN_EN
        dm_win_s    = dm_elig_s & (~if_elig_s | ptr_dm_q);
`else
        dm_win_s    = dm_elig_s;
`endif
        wd_inc_s    = wd_q + WD_W'(1);
        wd_expire_s = (TIMEOUT > 32'sd0) && (wd_inc_s == WD_W'(TIMEOUT));
    end

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        bus_err_d   = 1'b0;
        owner_dm_d  = owner_dm_q;
        err_d       = err_q;
        wd_d        = wd_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_dm_d    = ptr_dm_q;
`endif
        case (state_q)
            IDLE: begin
                if (dm_win_s) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_be_d    = dm_be;
                    owner_dm_d  = 1'b1;
                    err_d       = 1'b0;
                    wd_d        = {WD_W{1'b0}};
                    state_d     = BUSY_DM;
                end else if (if_elig_s) begin
                    // A fetch is a full-word read.
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = {DATA_W{1'b0}};
                    mem_be_d    = {BE_W{1'b1}};
                    owner_dm_d  = 1'b0;
                    err_d       = 1'b0;
                    wd_d        = {WD_W{1'b0}};
                    state_d     = BUSY_IF;
                end else begin
                    state_d     = IDLE;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack) begin
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = mem_rdata;
                    end else if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end else begin
                        // A store leaves the load word untouched.
                        dm_rdata_d = dm_rdata_q;
                    end
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end else if (wd_expire_s) begin
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = {DATA_W{1'b0}};
                    end else begin
                        dm_rdata_d = {DATA_W{1'b0}};
                    end
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else begin
                    wd_d      = wd_inc_s;
                end
            end
            DONE: begin
                if (owner_dm_q) begin
                    dm_ready_d = 1'b1;
                end else begin
                    if_ready_d = 1'b1;
                end
                bus_err_d = err_q;
`ifdef ARB_ROUND_ROBIN_EN
                ptr_dm_d  = ~owner_dm_q;
`endif
                state_d   = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_be_q    <= {BE_W{1'b0}};
            if_rdata_q  <= {DATA_W{1'b0}};
            dm_rdata_q  <= {DATA_W{1'b0}};
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            owner_dm_q  <= 1'b0;
            err_q       <= 1'b0;
            wd_q        <= {WD_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
            ptr_dm_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            bus_err_q   <= bus_err_d;
            owner_dm_q  <= owner_dm_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_dm_q    <= ptr_dm_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign bus_err   = bus_err_q;
    assign if_stall  = if_req & ~if_ready_q;
    assign dm_stall  = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios with literal expectations, followed by randomized traffic.
// A transaction-level model tracks the outstanding access by its grant edge
// number and a pending-completion flag. Every cycle, the DUT outputs are
// compared against that model on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [BW-1:0] dm_be = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          if_stall, dm_stall, bus_err;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .if_stall(if_stall), .dm_stall(dm_stall), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 CLK = ~CLK;

    // ---------------- transaction-level model ----------------
    logic          m_mem_req, m_mem_we, m_port_dm, m_pending, m_err;
    logic [AW-1:0] m_mem_addr;
    logic [DW-1:0] m_mem_wdata, m_if_rdata, m_dm_rdata;
    logic [BW-1:0] m_mem_be;
    logic          m_if_ready, m_dm_ready, m_bus_err;
    int            edge_no, m_grant_edge;
`ifdef ARB_ROUND_ROBIN_EN
    logic          m_last_dm;
`endif

    task automatic model_reset();
        m_mem_req = 1'b0; m_mem_we = 1'b0; m_mem_addr = '0; m_mem_wdata = '0; m_mem_be = '0;
        m_if_rdata = '0; m_dm_rdata = '0; m_if_ready = 1'b0; m_dm_ready = 1'b0;
        m_bus_err = 1'b0; m_port_dm = 1'b0; m_pending = 1'b0; m_err = 1'b0;
        edge_no = 0; m_grant_edge = 0;
`ifdef ARB_ROUND_ROBIN_EN
        m_last_dm = 1'b0;  // dm is favoured first after reset
`endif
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        logic prev_if, prev_dm, e_if, e_dm, pick_dm;
        prev_if = m_if_ready;
        prev_dm = m_dm_ready;
        m_if_ready = 1'b0; m_dm_ready = 1'b0; m_bus_err = 1'b0;
        if (m_pending) begin
            if (m_port_dm) m_dm_ready = 1'b1; else m_if_ready = 1'b1;
            m_bus_err = m_err;
            m_pending = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            m_last_dm = m_port_dm;
`endif
        end else if (m_mem_req) begin
            if (mem_ack) begin
                if (!m_port_dm) m_if_rdata = mem_rdata;
                else if (!m_mem_we) m_dm_rdata = mem_rdata;
                m_mem_req = 1'b0; m_pending = 1'b1; m_err = 1'b0;
            end else if (TO > 0 && (edge_no - m_grant_edge) == TO) begin
                if (m_port_dm) m_dm_rdata = '0; else m_if_rdata = '0;
                m_mem_req = 1'b0; m_pending = 1'b1; m_err = 1'b1;
            end
        end else begin
            e_if = if_req && !prev_if;
            e_dm = dm_req && !prev_dm;
`ifdef ARB_ROUND_ROBIN_EN
            pick_dm = e_dm && (!e_if || !m_last_dm);
`else
            pick_dm = e_dm;
`endif
            if (pick_dm) begin
                m_mem_req = 1'b1; m_port_dm = 1'b1; m_mem_we = dm_we;
                m_mem_addr = dm_addr; m_mem_wdata = dm_wdata; m_mem_be = dm_be;
                m_grant_edge = edge_no;
            end else if (e_if) begin
                m_mem_req = 1'b1; m_port_dm = 1'b0; m_mem_we = 1'b0;
                m_mem_addr = if_addr; m_mem_wdata = '0; m_mem_be = '1;
                m_grant_edge = edge_no;
            end
        end
        edge_no++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("mem_req",  64'(mem_req),  64'(m_mem_req));
        chk("if_ready", 64'(if_ready), 64'(m_if_ready));
        chk("dm_ready", 64'(dm_ready), 64'(m_dm_ready));
        chk("bus_err",  64'(bus_err),  64'(m_bus_err));
        chk("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
        chk("dm_rdata", 64'(dm_rdata), 64'(m_dm_rdata));
        chk("if_stall", 64'(if_stall), 64'(if_req & ~m_if_ready));
        chk("dm_stall", 64'(dm_stall), 64'(dm_req & ~m_dm_ready));
        if (m_mem_req) begin
            chk("mem_we",    64'(mem_we),    64'(m_mem_we));
            chk("mem_addr",  64'(mem_addr),  64'(m_mem_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_mem_wdata));
            chk("mem_be",    64'(mem_be),    64'(m_mem_be));
        end
    endtask

    // One clock: model follows the rising edge, comparison on the falling edge.
    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare_all();
    endtask

    logic [AW-1:0] grants[$];
    logic          prev_mreq;
    int            ack_pct;

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        // reset values
        chk("rst_mem_req",  64'(mem_req),  64'h0);
        chk("rst_mem_addr", 64'(mem_addr), 64'h0);
        chk("rst_mem_be",   64'(mem_be),   64'h0);
        chk("rst_if_ready", 64'(if_ready), 64'h0);
        chk("rst_dm_rdata", 64'(dm_rdata), 64'h0);
        RST = 1'b1;

        // single fetch
        if_req = 1'b1; if_addr = 32'h40;
        tick();
        chk("fetch_grant", 64'(mem_req), 64'h1);
        chk("fetch_addr",  64'(mem_addr), 64'h40);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h00500093;
        tick();
        mem_ack = 1'b0;
        chk("fetch_req_drop", 64'(mem_req), 64'h0);
        tick();
        chk("fetch_ready",   64'(if_ready), 64'h1);
        chk("fetch_rdata",   64'(if_rdata), 64'h00500093);
        chk("fetch_stall",   64'(if_stall), 64'h0);
        chk("model_fetch",   64'(m_if_rdata), 64'h00500093);
        if_req = 1'b0;
        tick();
        chk("fetch_pulse_end", 64'(if_ready), 64'h0);

        // store then load
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_be = 4'hF;
        tick();
        chk("store_we", 64'(mem_we), 64'h1);
        chk("store_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("store_ready", 64'(dm_ready), 64'h1);
        chk("store_rdata_kept", 64'(dm_rdata), 64'h0);
        dm_we = 1'b0;  // new load request kept asserted through the ready cycle
        tick();
        chk("own_ready_inelig", 64'(mem_req), 64'h0);
        tick();
        chk("load_we", 64'(mem_we), 64'h0);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("load_ready", 64'(dm_ready), 64'h1);
        chk("load_rdata", 64'(dm_rdata), 64'hDEADBEEF);
        chk("load_noerr", 64'(bus_err), 64'h0);
        dm_req = 1'b0;
        tick();

        // timeout
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        tick();
        for (int i = 1; i < TO; i++) begin
            tick();
            chk("to_busy", 64'(mem_req), 64'h1);
        end
        tick();
        chk("to_drop", 64'(mem_req), 64'h0);
        tick();
        chk("to_ready", 64'(dm_ready), 64'h1);
        chk("to_err",   64'(bus_err),  64'h1);
        chk("to_rdata", 64'(dm_rdata), 64'h0);
        dm_req = 1'b0;
        tick();
        chk("to_err_end", 64'(bus_err), 64'h0);

        // reset mid-access
        if_req = 1'b1; if_addr = 32'h80;
        tick();
        chk("rm_busy", 64'(mem_req), 64'h1);
        #2 RST = 1'b0;
        model_reset();
        #1;
        chk("rm_req",   64'(mem_req),  64'h0);
        chk("rm_rdata", 64'(if_rdata), 64'h0);
        compare_all();
        @(negedge CLK);
        RST = 1'b1;
        tick();
        chk("rm_regrant", 64'(mem_addr), 64'h80);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("rm_ready", 64'(if_ready), 64'h1);
        chk("rm_rdata2", 64'(if_rdata), 64'h12345678);
        if_req = 1'b0;
        tick();

        // stray ack in idle
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_ack = 1'b0;
        chk("stray_req", 64'(mem_req), 64'h0);
        tick();
        chk("stray_ifr", 64'(if_ready), 64'h0);
        chk("stray_dmr", 64'(dm_ready), 64'h0);

        // contention: both held continuously, memory acks at once
        if_req = 1'b1; if_addr = 32'h400;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        prev_mreq = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (mem_req && !prev_mreq) grants.push_back(mem_addr);
            prev_mreq = mem_req;
            mem_ack = mem_req;
        end
        chk("cont_count", 64'(grants.size() >= 4), 64'h1);
        if (grants.size() >= 4) begin
            chk("cont_g0", 64'(grants[0]), 64'h300);
            chk("cont_g1", 64'(grants[1]), 64'h400);
            chk("cont_g2", 64'(grants[2]), 64'h300);
            chk("cont_g3", 64'(grants[3]), 64'h400);
        end
        mem_ack = 1'b0;
        if_req = 1'b0; dm_req = 1'b0;
        // drain anything still in flight
        for (int i = 0; i < 4; i++) begin
            mem_ack = mem_req;
            tick();
        end
        mem_ack = 1'b0;

        // randomized traffic: fast memory, then slow memory with timeouts
        for (int ph = 0; ph < 2; ph++) begin
            ack_pct = (ph == 0) ? 50 : 5;
            for (int c = 0; c < 1500; c++) begin
                if (if_req && if_ready) begin
                    if_req = 1'($urandom_range(0, 1));
                    if_addr = $urandom & 32'hFFFF_FFFC;
                end else if (!if_req && $urandom_range(0, 2) == 0) begin
                    if_req = 1'b1;
                    if_addr = $urandom & 32'hFFFF_FFFC;
                end
                if ((dm_req && dm_ready) || (!dm_req && $urandom_range(0, 2) == 0)) begin
                    dm_req = (dm_req && dm_ready) ? 1'($urandom_range(0, 1)) : 1'b1;
                    dm_we = 1'($urandom_range(0, 1));
                    dm_addr = $urandom;
                    dm_wdata = $urandom;
                    dm_be = 4'($urandom);
                end
                mem_rdata = $urandom;
                if (mem_req) mem_ack = ($urandom_range(0, 99) < ack_pct);
                else mem_ack = ($urandom_range(0, 7) == 0);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
